// File: rtl/pulse_req_gen_if.sv
// ---------------------------------------------------------------------------
// pulse_req_gen_if
//   Request/acknowledge bundle between the pulse request generator and its
//   environment (the source-side event producer and the destination
//   synchroniser that returns the toggle).
//
// Parameters
//   CNT_W        width of src_pending; must match the generator's CNT_W
//
// Signals
//   src_pulse    single-cycle event request (src_clk domain)
//   ack_toggle   returned toggle from the destination domain (asynchronous)
//   src_toggle   registered request toggle towards the destination
//   src_busy     request outstanding or events pending
//   src_pending  queued events not yet launched
//   src_overflow one-cycle pulse when an event was dropped
//   src_timeout  sticky acknowledge-timeout flag
//
// Modports
//   master       the generator side (drives the toggle and the status)
//   slave        the environment side (drives pulse and returned toggle)
// ---------------------------------------------------------------------------
interface pulse_req_gen_if #(
    parameter int CNT_W = 4
);
    logic             src_pulse;
    logic             ack_toggle;
    logic             src_toggle;
    logic             src_busy;
    logic [CNT_W-1:0] src_pending;
    logic             src_overflow;
    logic             src_timeout;

    modport master (
        input  src_pulse,
        input  ack_toggle,
        output src_toggle,
        output src_busy,
        output src_pending,
        output src_overflow,
        output src_timeout
    );

    modport slave (
        output src_pulse,
        output ack_toggle,
        input  src_toggle,
        input  src_busy,
        input  src_pending,
        input  src_overflow,
        input  src_timeout
    );
endinterface

// File: rtl/pulse_req_gen.sv
// ---------------------------------------------------------------------------
// pulse_req_gen
//   Source side of a toggle-based pulse synchroniser. Each src_pulse event
//   becomes one inversion of src_toggle; a new inversion is only launched
//   once the destination has echoed the previous one back on ack_toggle, so
//   no toggle can be lost downstream. Events arriving while a request is in
//   flight are queued in a saturating counter and launched back to back as
//   acknowledges return.
//
// Parameters
//   DEPTH    synchroniser flops on ack_toggle (2..4)
//   CNT_W    pending-event counter width (1..8)
//   TIMEOUT  WAIT_ACK cycles before src_timeout sets (2..65535)
//
// Ports
//   src_clk  source-domain clock
//   src_rst  asynchronous active-high reset (deassertion synchronised
//            outside this block)
//   bus      pulse_req_gen_if.master: src_pulse, ack_toggle in;
//            src_toggle, src_busy, src_pending, src_overflow, src_timeout out
//
// Configuration
//   PULSE_REQ_GEN_TIMEOUT_EN  when defined, a 16-bit acknowledge watchdog
//            drives the sticky src_timeout flag; otherwise src_timeout is 0.
// ---------------------------------------------------------------------------
module pulse_req_gen #(
    parameter int DEPTH   = 2,
    parameter int CNT_W   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic               src_clk,
    input  logic               src_rst,
    pulse_req_gen_if.master    bus
);

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] PEND_MAX = '1;

    state_t           state;
    logic [DEPTH-1:0] ack_sync;
    logic             ack_s;
    logic             toggle_q;
    logic [CNT_W-1:0] pending_q;
    logic             overflow_q;
    logic             timeout_q;

    logic             match;
    logic             launch;

    // Only the last synchroniser flop is ever looked at.
    assign ack_s  = ack_sync[DEPTH-1];
    assign match  = (ack_s == toggle_q);

    // A launch needs something to send and a free channel: either idle, or
    // the previous toggle has just come back.
    assign launch = (bus.src_pulse || (pending_q != '0)) &&
                    ((state == IDLE) || match);

    always_ff @(posedge src_clk or posedge src_rst) begin
        if (src_rst) begin
            ack_sync   <= '0;
            state      <= IDLE;
            toggle_q   <= 1'b0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every decision
            // below uses the register values from before this edge.
            ack_sync   <= {ack_sync[DEPTH-2:0], bus.ack_toggle};
            overflow_q <= 1'b0;

            if (launch) begin
                toggle_q <= ~toggle_q;
            end

            case (state)
                IDLE: begin
                    // A stale mismatch in IDLE is deliberately ignored.
                    if (launch) begin
                        state <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (match && !launch) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // A pulse coinciding with a launch nets to zero: either it is the
            // event being launched, or it replaces the pending one consumed.
            if (bus.src_pulse && !launch) begin
                if (pending_q == PEND_MAX) begin
                    overflow_q <= 1'b1;
                end else begin
                    pending_q <= pending_q + 1'b1;
                end
            end else if (!bus.src_pulse && launch) begin
                pending_q <= pending_q - 1'b1;
            end
        end
    end

`ifdef PULSE_REQ_GEN_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    logic [15:0] wait_cnt;

    // Watchdog counts unanswered WAIT_ACK cycles; it only raises a flag and
    // never steers the FSM.
    always_ff @(posedge src_clk or posedge src_rst) begin
        if (src_rst) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else if (launch) begin
            wait_cnt <= '0;
        end else if ((state == WAIT_ACK) && !match) begin
            if (wait_cnt != 16'hFFFF) begin
                wait_cnt <= wait_cnt + 16'd1;
            end
            if (wait_cnt == TIMEOUT_LAST) begin
                timeout_q <= 1'b1;
            end
        end
    end
`else
    assign timeout_q = 1'b0;
`endif

    assign bus.src_toggle   = toggle_q;
    assign bus.src_busy     = (state == WAIT_ACK) || (pending_q != '0);
    assign bus.src_pending  = pending_q;
    assign bus.src_overflow = overflow_q;
    assign bus.src_timeout  = timeout_q;

endmodule

// File: tb/tb_pulse_req_gen.sv
// ---------------------------------------------------------------------------
// tb_pulse_req_gen
//   Directed bench for pulse_req_gen. u_a (CNT_W=4, TIMEOUT=8) covers launch
//   latency, ack round trip, queued relaunch, timeout and mid-request reset;
//   u_b (CNT_W=2) covers saturation, overflow and pulse-with-launch.
//   Inputs change 1 time unit after the rising edge; outputs are read there.
// ---------------------------------------------------------------------------
module tb_pulse_req_gen;

    logic src_clk = 1'b0;
    logic src_rst = 1'b1;

    always #5 src_clk = ~src_clk;

    pulse_req_gen_if #(.CNT_W(4)) ifa ();
    pulse_req_gen_if #(.CNT_W(2)) ifb ();

    pulse_req_gen #(.DEPTH(2), .CNT_W(4), .TIMEOUT(8)) u_a (
        .src_clk (src_clk),
        .src_rst (src_rst),
        .bus     (ifa)
    );

    pulse_req_gen #(.DEPTH(2), .CNT_W(2), .TIMEOUT(8)) u_b (
        .src_clk (src_clk),
        .src_rst (src_rst),
        .bus     (ifb)
    );

`ifdef PULSE_REQ_GEN_TIMEOUT_EN
    localparam logic TO_EXP = 1'b1;
`else
    localparam logic TO_EXP = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge src_clk);
        #1;
    endtask

    logic     exp_tog;
    int       exp_pend;

    initial begin
        ifa.src_pulse  = 1'b0;
        ifa.ack_toggle = 1'b0;
        ifb.src_pulse  = 1'b0;
        ifb.ack_toggle = 1'b0;

        // Reset state
        tick(2);
        check("rst_toggle",   ifa.src_toggle,   0);
        check("rst_busy",     ifa.src_busy,     0);
        check("rst_pending",  ifa.src_pending,  0);
        check("rst_overflow", ifa.src_overflow, 0);
        check("rst_timeout",  ifa.src_timeout,  0);

        // Release, then one pulse at cycle 5: toggle flips on that edge
        src_rst = 1'b0;
        tick(4);
        ifa.src_pulse = 1'b1;
        tick();
        ifa.src_pulse = 1'b0;
        check("launch_toggle",  ifa.src_toggle,  1);
        check("launch_busy",    ifa.src_busy,    1);
        check("launch_pending", ifa.src_pending, 0);

        // Ack returns: two sync edges, then IDLE on the third
        ifa.ack_toggle = 1'b1;
        tick(2);
        check("ack_busy_e2", ifa.src_busy, 1);
        tick();
        check("ack_idle_e3", ifa.src_busy, 0);

        // One launching pulse, then 3 queued while waiting
        ifa.src_pulse = 1'b1;
        tick();
        check("q_launch_toggle", ifa.src_toggle, 0);
        tick(3);
        ifa.src_pulse = 1'b0;
        check("q_pending3", ifa.src_pending, 3);
        check("q_toggle_held", ifa.src_toggle, 0);

        // Each echoed ack relaunches immediately, draining the queue
        exp_tog  = 1'b0;
        exp_pend = 3;
        for (int k = 0; k < 3; k++) begin
            ifa.ack_toggle = exp_tog;
            tick(2);
            check($sformatf("relaunch%0d_early", k), ifa.src_toggle, exp_tog);
            tick();
            exp_tog  = ~exp_tog;
            exp_pend = exp_pend - 1;
            check($sformatf("relaunch%0d_toggle", k), ifa.src_toggle, exp_tog);
            check($sformatf("relaunch%0d_pending", k), ifa.src_pending, exp_pend);
        end
        check("drain_busy", ifa.src_busy, 1);
        ifa.ack_toggle = 1'b1;
        tick(3);
        check("drain_idle", ifa.src_busy, 0);

        // Timeout: launch with the ack held mismatched
        ifa.src_pulse = 1'b1;
        tick();
        ifa.src_pulse = 1'b0;
        check("to_launch_toggle", ifa.src_toggle, 0);
        tick(7);
        check("to_before", ifa.src_timeout, 0);
        tick();
        check("to_set", ifa.src_timeout, TO_EXP);
        tick(3);
        check("to_sticky", ifa.src_timeout, TO_EXP);
        check("to_still_busy", ifa.src_busy, 1);

        // Queue two, then reset mid-WAIT_ACK
        ifa.src_pulse = 1'b1;
        tick(2);
        ifa.src_pulse = 1'b0;
        check("pre_rst_pending", ifa.src_pending, 2);
        src_rst = 1'b1;
        #1;
        check("arst_toggle",   ifa.src_toggle,   0);
        check("arst_busy",     ifa.src_busy,     0);
        check("arst_pending",  ifa.src_pending,  0);
        check("arst_overflow", ifa.src_overflow, 0);
        check("arst_timeout",  ifa.src_timeout,  0);
        tick();
        src_rst = 1'b0;
        tick(5);
        check("post_rst_toggle",  ifa.src_toggle,  0);
        check("post_rst_busy",    ifa.src_busy,    0);
        check("post_rst_pending", ifa.src_pending, 0);
        check("post_rst_timeout", ifa.src_timeout, 0);

        // u_b: 5 pulses with ack held; 5th is dropped
        ifb.src_pulse = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check($sformatf("b_ovf_after_p%0d", i), ifb.src_overflow,
                  (i == 5) ? 1 : 0);
        end
        ifb.src_pulse = 1'b0;
        check("b_pending_sat", ifb.src_pending, 3);
        tick();
        check("b_ovf_cleared", ifb.src_overflow, 0);
        check("b_pending_hold", ifb.src_pending, 3);
        check("b_toggle", ifb.src_toggle, 1);

        // Pulse on the relaunch edge: net pending change is zero, no drop
        ifb.ack_toggle = 1'b1;
        tick(2);
        ifb.src_pulse = 1'b1;
        tick();
        ifb.src_pulse = 1'b0;
        check("b_simul_toggle",  ifb.src_toggle,   0);
        check("b_simul_pending", ifb.src_pending,  3);
        tick();
        check("b_simul_no_ovf",  ifb.src_overflow, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pulse_req_gen.md
PULSE_REQ_GEN -- requirements
Module: pulse_req_gen

Interface
REQ-001 Parameter DEPTH, default 2, number of synchroniser flops on ack_toggle (legal 2..4).
REQ-002 Parameter CNT_W, default 4, width of the pending-event counter (legal 1..8).
REQ-003 Parameter TIMEOUT, default 1024, WAIT_ACK cycles before the timeout flag sets (legal 2..65535).
REQ-004 The block SHALL have a single clock, with asynchronous active-high reset.
REQ-005 Port src_clk  in  1  source-domain clock.
REQ-006 Port src_rst  in  1  asynchronous active-high reset.
REQ-007 Port src_pulse  in  1  single-cycle event request, synchronous to src_clk.
REQ-008 Port ack_toggle  in  1  asynchronous returned toggle from the destination domain (its dst_toggle).
REQ-009 Port src_toggle  out  1  registered request toggle to the destination synchroniser.
REQ-010 Port src_busy  out  1  high while a request is outstanding or events are pending.
REQ-011 Port src_pending  out  CNT_W  queued events not yet launched.
REQ-012 Port src_overflow  out  1  one-cycle pulse when an event is dropped.
REQ-013 Port src_timeout  out  1  sticky acknowledge-timeout flag.

Function
REQ-014 ack_toggle SHALL pass through DEPTH src_clk flops; ack_s is the last flop, and no other logic SHALL sample ack_toggle.
REQ-015 FSM states SHALL be IDLE and WAIT_ACK only.
REQ-016 Launch condition SHALL be (src_pulse or src_pending != 0), evaluated in IDLE, or in WAIT_ACK when ack_s == src_toggle.
REQ-017 On launch, src_toggle SHALL invert at that clock edge, and the state SHALL become or stay WAIT_ACK.
REQ-018 src_pulse high in IDLE with src_pending == 0 SHALL invert src_toggle at the same sampling edge (latency 1 cycle), leaving src_pending at 0.
REQ-019 In WAIT_ACK, ack_s == src_toggle with no launch condition SHALL return the FSM to IDLE at the next edge.
REQ-020 src_pending SHALL update by +1 per accepted src_pulse and -1 per launch; simultaneous pulse and launch SHALL give a net change that consumes the pending or current event.
REQ-021 src_pending SHALL saturate at 2^CNT_W-1.
REQ-022 A src_pulse that finds src_pending saturated with no launch on the same edge SHALL be dropped, and src_overflow SHALL be 1 for exactly the next cycle.
REQ-023 src_busy SHALL equal (state == WAIT_ACK) or (src_pending != 0), decoded combinationally from registers.
REQ-024 In IDLE, ack_s != src_toggle SHALL be ignored: no state change and no flag.
REQ-025 src_toggle SHALL invert at most once per acknowledge round trip, so no toggle is lost downstream.

Reset
REQ-026 While src_rst is high, all outputs and state SHALL reset immediately: src_toggle=0, synchroniser flops=0, state=IDLE, src_pending=0, src_overflow=0, src_timeout=0, timeout counter=0.
REQ-027 Reset asserted mid-WAIT_ACK SHALL discard the outstanding request and all pending events, with no flag raised.
REQ-028 Deassertion SHALL be synchronised externally; the first launch is allowed on the first edge after release.

Configuration
REQ-029 Macro PULSE_REQ_GEN_TIMEOUT_EN: when defined, a 16-bit counter SHALL clear on every launch and increment each WAIT_ACK cycle without a match.
REQ-030 When that counter reaches TIMEOUT, src_timeout SHALL set and stay set until reset; the FSM SHALL be unaffected.
REQ-031 When PULSE_REQ_GEN_TIMEOUT_EN is undefined, no counter SHALL exist and src_timeout SHALL be tied to 0.

Verification
REQ-032 The bench SHALL check reset release, then src_pulse at cycle 5 -> src_toggle 0->1 after that edge, src_busy=1, and src_pending=0.
REQ-033 The bench SHALL check ack_toggle 0->1 with DEPTH=2 -> state IDLE and src_busy=0 three edges later.
REQ-034 The bench SHALL check 3 pulses during WAIT_ACK -> src_pending=3, and each ack match gives an immediate relaunch, so 3 further toggles occur and src_pending reaches 0.
REQ-035 The bench SHALL check CNT_W=2, ack held, 5 pulses after launch -> src_pending=3 and src_overflow pulses once for the 5th.
REQ-036 The bench SHALL check, with the macro defined and TIMEOUT=8, ack held -> src_timeout=1 after 8 WAIT_ACK cycles and held until src_rst.
REQ-037 The bench SHALL check src_rst pulsed with src_pending=2 in WAIT_ACK -> all outputs 0, IDLE, and no further toggles.
